// File: rtl/stopwatch_counter_pkg.sv
// ============================================================================
// Module  : stopwatch_counter_pkg
// Brief   : Shared constants and types for the MM:SS stopwatch core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_counter_pkg;

  localparam int DIGIT_W     = 4;
  localparam int DEF_MIN_MAX = 59;
  localparam int DEF_SEC_MAX = 59;

  // bit3..bit0 = min_tens, min_ones, sec_tens, sec_ones
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_SEC  = 4'b0011;
  localparam logic [3:0] MASK_MIN  = 4'b1100;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } run_state_e;

endpackage

`default_nettype wire

// File: rtl/stopwatch_counter_if.sv
// ============================================================================
// Module  : stopwatch_counter_if
// Brief   : Control ticks in, BCD digits and blink mask out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_counter_if;
  import stopwatch_counter_pkg::*;

  logic               en_1hz;
  logic               en_2hz;
  logic               pause_pulse;
  logic               adj;
  logic               sel;
  logic [DIGIT_W-1:0] min_tens;
  logic [DIGIT_W-1:0] min_ones;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] sec_ones;
  logic [3:0]         blink_mask;
  logic               running;

  modport master (
    output en_1hz, en_2hz, pause_pulse, adj, sel,
    input  min_tens, min_ones, sec_tens, sec_ones, blink_mask, running
  );

  modport slave (
    input  en_1hz, en_2hz, pause_pulse, adj, sel,
    output min_tens, min_ones, sec_tens, sec_ones, blink_mask, running
  );

endinterface

`default_nettype wire

// File: rtl/stopwatch_counter_bcd_field_counter.sv
// ============================================================================
// Module  : bcd_field_counter
// Brief   : Two-digit BCD counter 00..MAX with a wrap strobe on MAX->00.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_field_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int MAX = DEF_SEC_MAX
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               inc_i,
  output logic      [DIGIT_W-1:0] tens_o,
  output logic      [DIGIT_W-1:0] ones_o,
  output logic                    wrap_o
);

  localparam logic [DIGIT_W-1:0] c_MAX_TENS = DIGIT_W'(MAX / 10);
  localparam logic [DIGIT_W-1:0] c_MAX_ONES = DIGIT_W'(MAX % 10);
  localparam logic [DIGIT_W-1:0] c_ONES_TOP = DIGIT_W'(9);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic               w_at_max;

  assign w_at_max = (tens_q == c_MAX_TENS) && (ones_q == c_MAX_ONES);
  assign wrap_o   = inc_i && w_at_max;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc_i) begin
      if (w_at_max) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == c_ONES_TOP) begin
        tens_d = tens_q + 1'b1;
        ones_d = '0;
      end else begin
        ones_d = ones_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_counter.sv
// ============================================================================
// Module  : stopwatch_counter
// Brief   : MM:SS BCD stopwatch core with run/pause and field adjust.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int MIN_MAX = DEF_MIN_MAX,
  parameter int SEC_MAX = DEF_SEC_MAX
) (
  input  wire logic          clk,
  input  wire logic          rst,
  stopwatch_counter_if.slave sw
);

  run_state_e state_q, state_d;
  logic       w_tick_norm;
  logic       w_tick_adj;
  logic       w_sec_inc;
  logic       w_min_inc;
  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic [3:0] w_mask;

  // Run/pause decision uses state_q, so a same-edge tick sees the pre-toggle state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sw.pause_pulse) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end
  end

  assign w_tick_norm = !sw.adj && sw.en_1hz && (state_q == ST_RUN);
  assign w_tick_adj  = sw.adj && sw.en_2hz;
  assign w_sec_inc   = w_tick_norm || (w_tick_adj && !sw.sel);
  assign w_min_inc   = (w_tick_norm && w_sec_wrap) || (w_tick_adj && sw.sel);

  bcd_field_counter #(
    .MAX (SEC_MAX)
  ) u_sec (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (w_sec_inc),
    .tens_o (sw.sec_tens),
    .ones_o (sw.sec_ones),
    .wrap_o (w_sec_wrap)
  );

  bcd_field_counter #(
    .MAX (MIN_MAX)
  ) u_min (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (w_min_inc),
    .tens_o (sw.min_tens),
    .ones_o (sw.min_ones),
    .wrap_o (w_min_wrap)
  );

  always_comb begin
    w_mask = MASK_NONE;
    if (!rst && sw.adj) begin
      w_mask = sw.sel ? MASK_MIN : MASK_SEC;
    end
  end

  assign sw.blink_mask = w_mask;
  assign sw.running    = (state_q == ST_RUN);

  // Minute wrap needs no downstream consumer; the full count rolls to 00:00 naturally
  logic w_unused;
  assign w_unused = w_min_wrap;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// ============================================================================
// Module  : tb_stopwatch_counter
// Brief   : Directed self-checking bench for the MM:SS stopwatch core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_counter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  stopwatch_counter_if sw_if ();

  stopwatch_counter #(
    .MIN_MAX (59),
    .SEC_MAX (59)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  logic [15:0] w_time;
  assign w_time = {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones};

  task automatic pulse(input logic e1, input logic e2, input logic pp);
    @(negedge clk);
    sw_if.en_1hz      = e1;
    sw_if.en_2hz      = e2;
    sw_if.pause_pulse = pp;
    @(negedge clk);
    sw_if.en_1hz      = 1'b0;
    sw_if.en_2hz      = 1'b0;
    sw_if.pause_pulse = 1'b0;
  endtask

  task automatic pulses(input int n, input logic e1, input logic e2);
    for (int i = 0; i < n; i++) pulse(e1, e2, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input int mm, input int ss);
    do_reset();
    sw_if.adj = 1'b1;
    sw_if.sel = 1'b1;
    pulses(mm, 1'b0, 1'b1);
    sw_if.sel = 1'b0;
    pulses(ss, 1'b0, 1'b1);
    sw_if.adj = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (w_time !== 16'h0000) begin
      $display("FAIL reset_time: got %h expected %h", w_time, 16'h0000); fails++;
    end
    checks++;
    if (sw_if.running !== 1'b1) begin
      $display("FAIL reset_running: got %b expected 1", sw_if.running); fails++;
    end
    checks++;
    if (sw_if.blink_mask !== 4'b0000) begin
      $display("FAIL reset_mask: got %b expected 0000", sw_if.blink_mask); fails++;
    end
    rst = 1'b0;
    pulses(61, 1'b1, 1'b0);
    checks++;
    if (w_time !== 16'h0101) begin
      $display("FAIL count_61: got %h expected %h", w_time, 16'h0101); fails++;
    end
  endtask

  task automatic test_wrap();
    load(59, 59);
    checks++;
    if (w_time !== 16'h5959) begin
      $display("FAIL preload_5959: got %h expected %h", w_time, 16'h5959); fails++;
    end
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (w_time !== 16'h0000) begin
      $display("FAIL wrap_full: got %h expected %h", w_time, 16'h0000); fails++;
    end
    load(9, 59);
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (w_time !== 16'h1000) begin
      $display("FAIL wrap_0959: got %h expected %h", w_time, 16'h1000); fails++;
    end
  endtask

  task automatic test_pause();
    do_reset();
    pulses(5, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    pulses(10, 1'b1, 1'b0);
    checks++;
    if (w_time !== 16'h0005) begin
      $display("FAIL paused_hold: got %h expected %h", w_time, 16'h0005); fails++;
    end
    checks++;
    if (sw_if.running !== 1'b0) begin
      $display("FAIL paused_running: got %b expected 0", sw_if.running); fails++;
    end
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (w_time !== 16'h0006 || sw_if.running !== 1'b1) begin
      $display("FAIL resume: got %h/%b expected %h/1", w_time, sw_if.running, 16'h0006); fails++;
    end
  endtask

  task automatic test_adjust();
    load(12, 58);
    sw_if.adj = 1'b1;
    sw_if.sel = 1'b0;
    pulses(3, 1'b0, 1'b1);
    checks++;
    if (w_time !== 16'h1201) begin
      $display("FAIL adj_sec: got %h expected %h", w_time, 16'h1201); fails++;
    end
    checks++;
    if (sw_if.blink_mask !== 4'b0011) begin
      $display("FAIL mask_sec: got %b expected 0011", sw_if.blink_mask); fails++;
    end
    sw_if.sel = 1'b1;
    pulses(48, 1'b0, 1'b1);
    checks++;
    if (w_time !== 16'h0001) begin
      $display("FAIL adj_min: got %h expected %h", w_time, 16'h0001); fails++;
    end
    checks++;
    if (sw_if.blink_mask !== 4'b1100) begin
      $display("FAIL mask_min: got %b expected 1100", sw_if.blink_mask); fails++;
    end
    pulses(3, 1'b1, 1'b0);
    checks++;
    if (w_time !== 16'h0001) begin
      $display("FAIL adj_ignores_1hz: got %h expected %h", w_time, 16'h0001); fails++;
    end
    pulse(1'b1, 1'b1, 1'b0);
    checks++;
    if (w_time !== 16'h0101) begin
      $display("FAIL adj_both_ticks: got %h expected %h", w_time, 16'h0101); fails++;
    end
    sw_if.adj = 1'b0;
    pulse(1'b1, 1'b1, 1'b0);
    checks++;
    if (w_time !== 16'h0102 || sw_if.blink_mask !== 4'b0000) begin
      $display("FAIL norm_both_ticks: got %h/%b expected %h/0000", w_time, sw_if.blink_mask, 16'h0102); fails++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulses(10, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    checks++;
    if (w_time !== 16'h0011 || sw_if.running !== 1'b0) begin
      $display("FAIL tick_and_pause: got %h/%b expected %h/0", w_time, sw_if.running, 16'h0011); fails++;
    end
    pulse(1'b0, 1'b0, 1'b1);
    // en_1hz held across three consecutive edges
    @(negedge clk);
    sw_if.en_1hz = 1'b1;
    repeat (3) @(negedge clk);
    sw_if.en_1hz = 1'b0;
    checks++;
    if (w_time !== 16'h0014) begin
      $display("FAIL consecutive_ticks: got %h expected %h", w_time, 16'h0014); fails++;
    end
  endtask

  task automatic test_async_reset();
    load(3, 27);
    checks++;
    if (w_time !== 16'h0327) begin
      $display("FAIL preload_0327: got %h expected %h", w_time, 16'h0327); fails++;
    end
    pulse(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst       = 1'b1;
    sw_if.adj = 1'b1;
    #1;
    checks++;
    if (w_time !== 16'h0000 || sw_if.running !== 1'b1 || sw_if.blink_mask !== 4'b0000) begin
      $display("FAIL async_reset: got %h/%b/%b expected 0000/1/0000", w_time, sw_if.running, sw_if.blink_mask); fails++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (sw_if.blink_mask !== 4'b0011) begin
      $display("FAIL mask_after_reset: got %b expected 0011", sw_if.blink_mask); fails++;
    end
    sw_if.adj = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (w_time !== 16'h0001) begin
      $display("FAIL resume_after_reset: got %h expected %h", w_time, 16'h0001); fails++;
    end
  endtask

  initial begin
    rst               = 1'b1;
    sw_if.en_1hz      = 1'b0;
    sw_if.en_2hz      = 1'b0;
    sw_if.pause_pulse = 1'b0;
    sw_if.adj         = 1'b0;
    sw_if.sel         = 1'b0;
    test_reset();
    test_wrap();
    test_pause();
    test_adjust();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
